// File: rtl/sqrt_pkg.sv
// Shared constants for squareroot_stream: octave-based piecewise-linear sqrt
// coefficients in Q2.COEF_FRAC and the signed floor-halving helper.
package sqrt_pkg;

  localparam int unsigned COEF_FRAC = 16;
  localparam int unsigned T_W       = COEF_FRAC + 2;
  localparam int unsigned EW        = 8;

  typedef logic [T_W-1:0]       coef_a_t;
  typedef logic [COEF_FRAC-1:0] coef_b_t;

  // Even octave: sqrt over [1,2) ~ 1 + (sqrt2-1)*m; odd octave: sqrt2 + (2-sqrt2)*m.
  localparam coef_a_t A_EVEN = T_W'(65536);
  localparam coef_b_t B_EVEN = COEF_FRAC'(27146);
  localparam coef_a_t A_ODD  = T_W'(92682);
  localparam coef_b_t B_ODD  = COEF_FRAC'(38390);

  function automatic int floor_half(input int k);
    return k >>> 1;
  endfunction

endpackage

// File: rtl/lead_one_enc.sv
// Priority encoder: index of the most significant set bit of vec_i, plus an
// all-zero flag (pos_o is 0 when zero_o is set).
module lead_one_enc #(
  parameter int unsigned W  = 15,
  parameter int unsigned PW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [PW-1:0] pos_o,
  output logic          zero_o
);

  always_comb begin
    pos_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec_i[i]) pos_o = PW'(i);
    end
    zero_o = (vec_i == '0);
  end

endmodule

// File: rtl/squareroot_stream.sv
// 3-stage piecewise-linear square root with valid/ready stream, channel tag and
// negative-input flag. Define SQRT_ERR_CNT_EN to add the saturating err_count port.
module squareroot_stream
  import sqrt_pkg::*;
#(
  parameter int unsigned BITSIZE   = 16,
  parameter int unsigned FRAC_BITS = 11,
  parameter int unsigned CH_W      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] in_data,
  input  logic [CH_W-1:0]    in_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] out_data,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_err
`ifdef SQRT_ERR_CNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam int unsigned PW  = $clog2(BITSIZE - 1);
  localparam int unsigned MW  = BITSIZE - 2;
  localparam int unsigned PRW = COEF_FRAC + MW;
  localparam int unsigned WW  = T_W + BITSIZE + 2;
  localparam logic [BITSIZE-1:0] MAX_POS = {1'b0, {(BITSIZE-1){1'b1}}};

  logic adv;

  logic               s1_valid_q;
  logic [BITSIZE-2:0] s1_x_q;
  logic [CH_W-1:0]    s1_ch_q;
  logic [PW-1:0]      s1_p_q;
  logic               s1_zero_q;
  logic               s1_neg_q;

  logic               s2_valid_q;
  logic [CH_W-1:0]    s2_ch_q;
  logic               s2_neg_q;
  logic               s2_zero_q;
  logic [T_W-1:0]     s2_t_q, s2_t_d;
  logic [EW-1:0]      s2_e_q, s2_e_d;

  logic               out_valid_q;
  logic [BITSIZE-1:0] out_data_q;
  logic [CH_W-1:0]    out_ch_q;
  logic               out_err_q;

  // Whole pipe moves in lockstep; only a held result blocks it.
  assign adv       = out_ready | ~out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_err   = out_err_q;

  logic [PW-1:0] lo_pos;
  logic          lo_zero;

  lead_one_enc #(
    .W  (BITSIZE - 1),
    .PW (PW)
  ) u_lead_one (
    .vec_i  (in_data[BITSIZE-2:0]),
    .pos_o  (lo_pos),
    .zero_o (lo_zero)
  );

  logic signed [31:0] s2_k;
  logic [PW-1:0]      s2_shamt;
  logic [MW-1:0]      s2_mant;
  logic [PRW-1:0]     s2_prod;
  coef_a_t            s2_coef_a;
  coef_b_t            s2_coef_b;

  always_comb begin
    s2_k     = 32'(s1_p_q) - 32'(FRAC_BITS);
    // Shifting the leading one up to bit MW leaves the mantissa in Q0.MW.
    s2_shamt = PW'(MW) - s1_p_q;
    s2_mant  = MW'(s1_x_q << s2_shamt);
    if (s2_k[0]) begin
      s2_coef_a = A_ODD;
      s2_coef_b = B_ODD;
    end else begin
      s2_coef_a = A_EVEN;
      s2_coef_b = B_EVEN;
    end
    s2_prod = PRW'(s2_coef_b) * PRW'(s2_mant);
    s2_t_d  = s2_coef_a + T_W'(s2_prod >> MW);
    s2_e_d  = EW'(floor_half(s2_k));
  end

  logic [31:0]        s3_sh;
  logic [31:0]        s3_rsh;
  logic [WW-1:0]      s3_wide;
  logic [BITSIZE-1:0] s3_y;

  always_comb begin
    s3_sh  = {{(32-EW){s2_e_q[EW-1]}}, s2_e_q} + 32'(FRAC_BITS) - 32'(COEF_FRAC);
    s3_rsh = '0 - s3_sh;
    if (!s3_sh[31]) begin
      s3_wide = WW'(s2_t_q) << s3_sh;
    end else begin
      s3_wide = (WW'(s2_t_q) + (WW'(1) << (s3_rsh - 32'd1))) >> s3_rsh;
    end
    if (s3_wide > WW'(MAX_POS)) s3_y = MAX_POS;
    else                        s3_y = s3_wide[BITSIZE-1:0];
    if (!s2_valid_q || s2_neg_q || s2_zero_q) s3_y = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_ch_q     <= '0;
      s1_p_q      <= '0;
      s1_zero_q   <= 1'b0;
      s1_neg_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_ch_q     <= '0;
      s2_neg_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_t_q      <= '0;
      s2_e_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_x_q      <= in_data[BITSIZE-2:0];
      s1_ch_q     <= in_ch;
      s1_p_q      <= lo_pos;
      s1_zero_q   <= lo_zero & ~in_data[BITSIZE-1];
      s1_neg_q    <= in_data[BITSIZE-1];
      s2_valid_q  <= s1_valid_q;
      s2_ch_q     <= s1_ch_q;
      s2_neg_q    <= s1_neg_q;
      s2_zero_q   <= s1_zero_q;
      s2_t_q      <= s2_t_d;
      s2_e_q      <= s2_e_d;
      out_valid_q <= s2_valid_q;
      out_data_q  <= s3_y;
      out_ch_q    <= s2_valid_q ? s2_ch_q : '0;
      out_err_q   <= s2_valid_q & s2_neg_q;
    end
  end

`ifdef SQRT_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid_q && out_ready && out_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_squareroot_stream.sv
// Self-checking bench for squareroot_stream: directed octave/special points,
// full-rate streaming, backpressure, mid-stream reset and a random sweep.
module tb_squareroot_stream;

  localparam int BITSIZE   = 16;
  localparam int FRAC_BITS = 11;
  localparam int CH_W      = 2;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  ch;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_ch = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_err;
`ifdef SQRT_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  squareroot_stream #(
    .BITSIZE   (BITSIZE),
    .FRAC_BITS (FRAC_BITS),
    .CH_W      (CH_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_err   (out_err)
`ifdef SQRT_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Golden model: octave split by plain integer arithmetic, coefficients from sqrt(2).
  function automatic logic [15:0] ref_sqrt(input logic [15:0] x);
    longint xi, a, b, m, t, r;
    int p, k, e, sh;
    if (x[15] || x == 16'h0000) return 16'h0000;
    xi = longint'(x);
    p = 0;
    for (int i = 0; i < 15; i++) if (xi >= (longint'(1) << i)) p = i;
    k = p - FRAC_BITS;
    e = (k >= 0) ? k / 2 : -((1 - k) / 2);
    if (k % 2 != 0) begin
      a = longint'($rtoi($sqrt(2.0) * 65536.0 + 0.5));
      b = longint'($rtoi((2.0 - $sqrt(2.0)) * 65536.0 + 0.5));
    end else begin
      a = 65536;
      b = longint'($rtoi(($sqrt(2.0) - 1.0) * 65536.0 + 0.5));
    end
    m = ((xi - (longint'(1) << p)) * 16384) / (longint'(1) << p);
    t = a + (b * m) / 16384;
    sh = e + FRAC_BITS - 16;
    if (sh >= 0) r = t * (longint'(1) << sh);
    else         r = (t + (longint'(1) << (-sh - 1))) / (longint'(1) << (-sh));
    if (r > 32767) r = 32767;
    return 16'(r);
  endfunction

  function automatic logic [15:0] rand_pos();
    logic [15:0] v;
    v = 16'($urandom_range(0, 32767));
    return v >> $urandom_range(0, 14);
  endfunction

  logic [15:0] dir_x [9] = '{16'h0800, 16'h2000, 16'h0200, 16'h1000, 16'h0400,
                             16'h0C00, 16'h0000, 16'h8400, 16'h7FFF};
  logic [15:0] dir_y [9] = '{16'h0800, 16'h1000, 16'h0400, 16'h0B50, 16'h05A8,
                             16'h09A8, 16'h0000, 16'h0000, 16'h2000};
  logic        dir_e [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_data got %h want 0000", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_bad++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", out_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    logic [1:0] tag;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tag = 2'(i);
      in_valid = 1'b1; in_data = dir_x[i]; in_ch = tag; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
        if (c > 1) @(negedge clk);
        if (out_valid === 1'b1) lat = c;
      end
      n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL dir%0d_latency got %0d want 3", i, lat); end
      n_cmp++; if (out_data !== dir_y[i]) begin n_bad++; $display("FAIL dir%0d_data x=%h got %h want %h", i, dir_x[i], out_data, dir_y[i]); end
      n_cmp++; if (out_err !== dir_e[i]) begin n_bad++; $display("FAIL dir%0d_err got %b want %b", i, out_err, dir_e[i]); end
      n_cmp++; if (out_ch !== tag) begin n_bad++; $display("FAIL dir%0d_ch got %0d want %0d", i, out_ch, tag); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (c < 8);
      in_data = rand_pos();
      in_ch = 2'(c);
      #1;
      if (c < 8) begin
        e.d = ref_sqrt(in_data); e.ch = in_ch; e.err = 1'b0; q.push_back(e);
      end
      if (c >= 3 && c < 11) begin
        e = q.pop_front();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid c=%0d got %b want 1", c, out_valid); end
        n_cmp++; if (out_data !== e.d) begin n_bad++; $display("FAIL b2b_data c=%0d got %h want %h", c, out_data, e.d); end
        n_cmp++; if (out_ch !== e.ch) begin n_bad++; $display("FAIL b2b_ch c=%0d got %0d want %0d", c, out_ch, e.ch); end
      end else if (c == 11) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_tail_valid got %b want 0", out_valid); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, extra = 0;
    logic [15:0] hold_d = '0;
    logic [1:0]  hold_ch = '0;
    logic        was_stall = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      in_valid = (sent < 8);
      in_data = rand_pos();
      in_ch = 2'(sent % 4);
      out_ready = !(c >= 4 && c < 9);
      #1;
      if (out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, in_ready); end
        if (was_stall) begin
          n_cmp++; if (out_data !== hold_d) begin n_bad++; $display("FAIL bp_hold_data c=%0d got %h want %h", c, out_data, hold_d); end
          n_cmp++; if (out_ch !== hold_ch) begin n_bad++; $display("FAIL bp_hold_ch c=%0d got %0d want %0d", c, out_ch, hold_ch); end
        end
        hold_d = out_data; hold_ch = out_ch; was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL bp_unexpected got %h want none", out_data);
        end else begin
          e = q.pop_front();
          n_cmp++; if (out_data !== e.d) begin n_bad++; $display("FAIL bp_data got %h want %h", out_data, e.d); end
          n_cmp++; if (out_ch !== e.ch) begin n_bad++; $display("FAIL bp_ch got %0d want %0d", out_ch, e.ch); end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        e.d = ref_sqrt(in_data); e.ch = in_ch; e.err = 1'b0; q.push_back(e); sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", got); end
    repeat (5) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL bp_duplicate got %0d extra want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h2000 + 16'(i * 16'h0100); in_ch = 2'd3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_inflight got %b want 1", out_valid); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL rmid_data got %h want 0000", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_bad++; $display("FAIL rmid_ch got %0d want 0", out_ch); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b want 0", out_err); end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rmid_drained got %0d outputs want 0", seen); end
  endtask

  task automatic test_negatives();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 200 && got < 37; c++) begin
      @(negedge clk);
      in_valid = (sent < 37);
      in_data = 16'h8000 | 16'($urandom_range(0, 32767));
      in_ch = 2'($urandom);
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        e = q.pop_front();
        n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL neg_data got %h want 0000", out_data); end
        n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL neg_err got %b want 1", out_err); end
        n_cmp++; if (out_ch !== e.ch) begin n_bad++; $display("FAIL neg_ch got %0d want %0d", out_ch, e.ch); end
        got++;
      end
      if (in_valid && in_ready) begin
        e.d = 16'h0; e.ch = in_ch; e.err = 1'b1; q.push_back(e); sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 37) begin n_bad++; $display("FAIL neg_count got %0d want 37", got); end
    @(negedge clk);
`ifdef SQRT_ERR_CNT_EN
    n_cmp++; if (err_count !== 16'd37) begin n_bad++; $display("FAIL err_count got %0d want 37", err_count); end
`endif
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0;
    for (int c = 0; c < 30000 && got < 10000; c++) begin
      @(negedge clk);
      in_valid = (sent < 10000) && ($urandom_range(0, 4) != 0);
      in_data = rand_pos();
      in_ch = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rand_unexpected got %h want none", out_data);
        end else begin
          e = q.pop_front();
          n_cmp++; if (out_data !== e.d) begin n_bad++; $display("FAIL rand_data got %h want %h", out_data, e.d); end
          n_cmp++; if (out_ch !== e.ch) begin n_bad++; $display("FAIL rand_ch got %0d want %0d", out_ch, e.ch); end
          n_cmp++; if (out_err !== e.err) begin n_bad++; $display("FAIL rand_err got %b want %b", out_err, e.err); end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        e.d = ref_sqrt(in_data); e.ch = in_ch; e.err = 1'b0; q.push_back(e); sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 10000) begin n_bad++; $display("FAIL rand_count got %0d want 10000", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_negatives();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
